byte_to_word_assembler: RTL

Receives a stream of bytes, least significant byte first, and reassembles them into DATAWIDTH-bit words. It is the receive-side counterpart of the team's word-to-byte serializer. It sits at the far end of a byte link and presents complete words to downstream logic through a valid/ready handshake. An optional inter-byte timeout discards stalled partial words.

---
 rtl/byte_to_word_assembler.sv | 81 ++++++++
 1 files changed

// File: rtl/byte_to_word_assembler.sv
// Reassembles an LSB-first byte stream into DATAWIDTH-bit words.
// Words leave through a valid/ready handshake; stalled partial words can time out.
module byte_to_word_assembler #(
    parameter  int DATAWIDTH = 16,
    parameter  int TIMEOUT   = 0,
    localparam int NBYTES    = (DATAWIDTH + 7) / 8,
    localparam int IDXW      = $clog2(NBYTES) + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [7:0]           i_Byte,
    input  logic                 i_ByteValid,
    output logic                 o_ByteReady,
    output logic [DATAWIDTH-1:0] o_Data,
    output logic                 o_DataValid,
    input  logic                 i_DataReady,
    output logic [IDXW-1:0]      o_ByteIdx,
    output logic                 o_Timeout
);

    localparam int AW   = 8 * NBYTES;
    localparam int CW   = $clog2(TIMEOUT + 1) + 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [AW-1:0] asm_q;
    logic [AW-1:0] full_word;
    logic [CW-1:0] idle_q;
    logic          accept;
    logic          last;
    logic          partial;
    logic          expire;

    // A byte may enter whenever the output slot is free or draining now.
    assign o_ByteReady = !o_DataValid || i_DataReady;
    assign accept      = i_ByteValid && o_ByteReady;
    assign last        = (o_ByteIdx == IDXW'(NBYTES - 1));
    assign partial     = (o_ByteIdx != '0);
    assign expire      = (TIMEOUT > 0) && partial && !accept
                         && (idle_q == CW'(TLIM));

    // Merge the incoming byte into its slot of the assembly register.
    always_comb begin
        full_word = asm_q;
        full_word[8*int'(o_ByteIdx) +: 8] = i_Byte;
    end

    // Byte index, assembly register, output word and idle counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            asm_q       <= '0;
            idle_q      <= '0;
            o_Data      <= '0;
            o_DataValid <= 1'b0;
            o_ByteIdx   <= '0;
            o_Timeout   <= 1'b0;
        end else begin
            o_Timeout <= 1'b0;
            if (o_DataValid && i_DataReady)
                o_DataValid <= 1'b0;
            if (accept) begin
                asm_q  <= full_word;
                idle_q <= '0;
                if (last) begin
                    // Bits above DATAWIDTH in the final byte are dropped here.
                    o_Data      <= full_word[DATAWIDTH-1:0];
                    o_DataValid <= 1'b1;
                    o_ByteIdx   <= '0;
                end else begin
                    o_ByteIdx <= o_ByteIdx + IDXW'(1);
                end
            end else if (expire) begin
                o_ByteIdx <= '0;
                idle_q    <= '0;
                o_Timeout <= 1'b1;
            end else if (partial && (TIMEOUT > 0)) begin
                idle_q <= idle_q + CW'(1);
            end
        end
    end

endmodule
